// File: rtl/morse_serializer.sv
// morse_serializer
//   Plays one 5-symbol Morse character out as a timed on/off tone line.
//   The symbols are taken MSB first; 1 = dot and 0 = dash. Intra-character
//   gaps separate the symbols, and a letter gap closes the character.
//   The done pulse comes in the first idle cycle after that gap.
//
// Parameters
//   UNIT_CYCLES  : clock cycles per Morse time unit (>= 1)
//   DOT_UNITS    : tone-on units for a dot (>= 1)
//   DASH_UNITS   : tone-on units for a dash (>= 1)
//   GAP_UNITS    : tone-off units between symbols (>= 1)
//   LETTER_UNITS : tone-off units after the last symbol (>= 1)
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   code  : symbols, code[4] sent first; 1 = dot, 0 = dash
//   start : request to send code; sampled only while idle
//   busy  : character in progress (registered)
//   tone  : Morse key output, 1 = key down (registered)
//   done  : one-cycle pulse at character completion (registered)
module morse_serializer #(
   parameter int unsigned UNIT_CYCLES  = 2,
   parameter int unsigned DOT_UNITS    = 1,
   parameter int unsigned DASH_UNITS   = 3,
   parameter int unsigned GAP_UNITS    = 1,
   parameter int unsigned LETTER_UNITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] code,
   input  logic       start,
   output logic       busy,
   output logic       tone,
   output logic       done
);

   localparam int unsigned DOT_LEN    = DOT_UNITS    * UNIT_CYCLES;
   localparam int unsigned DASH_LEN   = DASH_UNITS   * UNIT_CYCLES;
   localparam int unsigned GAP_LEN    = GAP_UNITS    * UNIT_CYCLES;
   localparam int unsigned LETTER_LEN = LETTER_UNITS * UNIT_CYCLES;
   localparam int unsigned MAX_MARK   = (DOT_LEN > DASH_LEN) ? DOT_LEN : DASH_LEN;
   localparam int unsigned MAX_OFF    = (GAP_LEN > LETTER_LEN) ? GAP_LEN : LETTER_LEN;
   localparam int unsigned MAX_LEN    = (MAX_MARK > MAX_OFF) ? MAX_MARK : MAX_OFF;
   localparam int unsigned CW         = $clog2(MAX_LEN + 1);

   // Counters are loaded with length-1 and the phase ends when they hit zero,
   // so every phase lasts exactly its length with no idle cycle between phases.
   localparam logic [CW-1:0] DOT_LOAD    = CW'(DOT_LEN - 1);
   localparam logic [CW-1:0] DASH_LOAD   = CW'(DASH_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] LETTER_LOAD = CW'(LETTER_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      SPACE,
      LETTER
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [4:0]    shreg, shreg_n;
   logic          tone_n, busy_n, done_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         tone  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         tone  <= tone_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      done_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               shreg_n = code;
               idx_n   = '0;
               cnt_n   = code[4] ? DOT_LOAD : DASH_LOAD;
               state_n = MARK;
            end
         end

         MARK: begin
            if (cnt == '0) begin
               if (idx < 3'd4) begin
                  cnt_n   = GAP_LOAD;
                  state_n = SPACE;
               end else begin
                  cnt_n   = LETTER_LOAD;
                  state_n = LETTER;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         SPACE: begin
            if (cnt == '0) begin
               // shreg[4] is the symbol just sent; shreg[3] is the next one.
               idx_n   = idx + 3'd1;
               shreg_n = {shreg[3:0], 1'b0};
               cnt_n   = shreg[3] ? DOT_LOAD : DASH_LOAD;
               state_n = MARK;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         LETTER: begin
            if (cnt == '0) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         default: state_n = IDLE;
      endcase

      // Outputs are decoded from the next state and registered, which
      // makes tone/busy rise on the accepting edge itself.
      tone_n = (state_n == MARK);
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_morse_serializer.sv
module tb_morse_serializer;

   localparam int unsigned UC  = 2;
   localparam int unsigned DOT = 1;
   localparam int unsigned DSH = 3;
   localparam int unsigned GAP = 1;
   localparam int unsigned LET = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] code = 5'b11111;
   logic       start = 1'b1;
   logic       busy, tone, done;

   int n_cmp = 0;
   int n_err = 0;

   morse_serializer #(
      .UNIT_CYCLES (UC),
      .DOT_UNITS   (DOT),
      .DASH_UNITS  (DSH),
      .GAP_UNITS   (GAP),
      .LETTER_UNITS(LET)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .code (code),
      .start(start),
      .busy (busy),
      .tone (tone),
      .done (done)
   );

   always #5 clk = ~clk;

   // Model: an accepted character becomes a queue of per-cycle expected
   // {tone,busy,done} triples built directly from the Morse timing rules.
   logic [2:0] mq[$];
   logic [2:0] exp_tbd = 3'b000;
   bit         chk_en = 1'b0;

   function automatic void build_char(input logic [4:0] c);
      int unsigned len;
      for (int i = 0; i < 5; i++) begin
         len = c[4-i] ? DOT * UC : DSH * UC;
         for (int k = 0; k < int'(len); k++) mq.push_back(3'b110);
         if (i < 4)
            for (int k = 0; k < int'(GAP * UC); k++) mq.push_back(3'b010);
      end
      for (int k = 0; k < int'(LET * UC); k++) mq.push_back(3'b010);
      mq.push_back(3'b001);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            exp_tbd = 3'b000;
         end else begin
            if (mq.size() == 0 && start) build_char(code);
            if (mq.size() > 0) exp_tbd = mq.pop_front();
            else exp_tbd = 3'b000;
         end
         chk_en = 1'b1;
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            n_cmp++;
            if ({tone, busy, done} !== exp_tbd) begin
               n_err++;
               $display("FAIL cycle_model t=%0t tone/busy/done got %b expected %b",
                        $time, {tone, busy, done}, exp_tbd);
            end
         end
      end
   end

   // Measurement of DUT behaviour per character, for literal checks.
   int         busy_cnt = 0, tone_cnt = 0;
   int         last_busy = 0, last_tone = 0;
   logic [39:0] pat = '0, last_pat = '0;
   int         done_cnt = 0;
   int         cyc = 0, last_done_cyc = -1, done_period = 0;
   logic       prev_busy = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (busy && !prev_busy) begin
            busy_cnt = 1;
            tone_cnt = tone ? 1 : 0;
            pat      = {39'b0, tone};
         end else if (busy) begin
            busy_cnt++;
            if (tone) tone_cnt++;
            pat = {pat[38:0], tone};
         end
         if (done) begin
            last_busy = busy_cnt;
            last_tone = tone_cnt;
            last_pat  = pat;
            done_cnt++;
            if (last_done_cyc >= 0) done_period = cyc - last_done_cyc;
            last_done_cyc = cyc;
         end
         prev_busy = busy;
      end
   end

   task automatic chk(input string name, input int got, input int expv);
      n_cmp++;
      if (got != expv) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic wait_done(input string name, input int maxc);
      bit seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s_timeout got no done expected done within %0d cycles", name, maxc);
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [4:0] c);
      @(negedge clk);
      code  = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int dc;
      // Reset held with start/code active.
      repeat (3) @(negedge clk);
      chk("reset_tone", int'(tone), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_tone", int'(tone), 0);

      // Digit 5.
      send(5'b11111);
      wait_done("digit5", 60);
      chk("digit5_busy", last_busy, 24);
      chk("digit5_tone", last_tone, 10);

      // Digit 0.
      send(5'b00000);
      wait_done("digit0", 80);
      chk("digit0_busy", last_busy, 44);
      chk("digit0_tone", last_tone, 30);

      // Digit 1 with code change and start pulse mid-character.
      send(5'b10000);
      repeat (10) @(negedge clk);
      code  = 5'b11111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("digit1", 80);
      chk("digit1_busy", last_busy, 40);
      chk("digit1_tone", last_tone, 26);
      n_cmp++;
      if (last_pat !== 40'b1100_1111_1100_1111_1100_1111_1100_1111_1100_0000) begin
         n_err++;
         $display("FAIL digit1_pattern got %b expected %b", last_pat,
                  40'b1100_1111_1100_1111_1100_1111_1100_1111_1100_0000);
      end
      dc = done_cnt;
      repeat (30) @(negedge clk);
      chk("digit1_no_second_char", done_cnt, dc);

      // Reset mid-character.
      send(5'b10000);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_tone", int'(tone), 0);
      dc = done_cnt;
      repeat (50) @(negedge clk);
      chk("midreset_no_done", done_cnt, dc);
      send(5'b11111);
      wait_done("after_reset", 60);
      chk("after_reset_busy", last_busy, 24);
      chk("after_reset_tone", last_tone, 10);

      // Back-to-back characters with start held high.
      @(negedge clk);
      code  = 5'b11111;
      start = 1'b1;
      wait_done("b2b_1", 60);
      wait_done("b2b_2", 60);
      chk("b2b_period", done_period, 25);
      chk("b2b_busy", last_busy, 24);
      wait_done("b2b_3", 60);
      chk("b2b_period2", done_period, 25);
      start = 1'b0;
      wait_done("b2b_last", 60);
      repeat (5) @(negedge clk);
      chk("final_idle_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/morse_serializer.md
# morse_serializer

Sequential back end of the binary-to-Morse path. Accepts one 5-symbol Morse character from the combinational encoder stage (symbols s1..s5, 1 = dot, 0 = dash, s1 sent first) and plays it out as a timed on/off `tone` line suitable for an LED or buzzer. Standard Morse spacing applies: intra-character gaps between symbols and a closing inter-character gap. A `start`/`busy`/`done` handshake lets the upstream control pace characters.

## Interface
- `UNIT_CYCLES`, default 2: clock cycles per Morse time unit; must be ≥ 1.
- `DOT_UNITS`, default 1: tone-on length of a dot, in units; ≥ 1.
- `DASH_UNITS`, default 3: tone-on length of a dash, in units; ≥ 1.
- `GAP_UNITS`, default 1: tone-off gap between symbols of one character; ≥ 1.
- `LETTER_UNITS`, default 3: tone-off gap after the last symbol, before `done`; ≥ 1.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `code` in 5: symbols, `code[4]`=s1 (sent first) … `code[0]`=s5; 1 = dot, 0 = dash.
- `start` in 1: request to send `code`; connects to the encoder's `ready`.
- `busy` out 1: character in progress; `start` ignored while high.
- `tone` out 1: Morse output, 1 = key down.
- `done` out 1: one-cycle pulse at character completion.

## Operation
- States: IDLE, MARK (tone on), SPACE (intra-char gap), LETTER (final gap).
- IDLE: `tone`=0, `busy`=0. On `start`=1, latch `code` into shift register, symbol index ← 0, load duration counter for symbol `code[4]`, go to MARK.
- MARK: `tone`=1 for DOT_UNITS·UNIT_CYCLES (dot) or DASH_UNITS·UNIT_CYCLES (dash) cycles. At expiry: if symbol index < 4 → SPACE; else → LETTER.
- SPACE: `tone`=0 for GAP_UNITS·UNIT_CYCLES cycles, then advance symbol index, shift next symbol, → MARK.
- LETTER: `tone`=0 for LETTER_UNITS·UNIT_CYCLES cycles, then → IDLE with `done`=1 for that one cycle.
- `code` latched only at accept; changes on `code` during `busy` have no effect.
- `start` while `busy`=1 is dropped (not queued).
- Counter width = clog2 of max(DASH_UNITS, LETTER_UNITS, GAP_UNITS, DOT_UNITS)·UNIT_CYCLES + 1; no wrap can occur within a phase.
- All outputs registered.

## Timing
- Reset (synchronous): next edge forces IDLE, `tone`=0, `busy`=0, `done`=0, counters and shift register cleared. Reset mid-character aborts immediately; no `done` pulse.
- Accept: `start` sampled high at edge k in IDLE → `busy`=1 and `tone`=1 from edge k onward (zero-cycle lead).
- Each phase lasts exactly its computed cycle count; phase transitions are back-to-back, no idle cycles between phases.
- Total `busy` cycles = Σ mark lengths + 4·GAP_UNITS·UNIT_CYCLES + LETTER_UNITS·UNIT_CYCLES.
- `done` is high in the first cycle after `busy` falls, with `busy`=0 and `tone`=0 in that cycle.
- A `start` in the `done` cycle is accepted: `tone`/`busy` rise at that edge, and `done` clears the following cycle. This gives back-to-back characters with no extra gap beyond LETTER.
- Reset and `start` high on the same edge: reset wins.

## Test plan
- Reset: hold `reset` 3 cycles with `start`=1, `code`=5'b11111 → `tone`=0, `busy`=0, `done`=0 throughout and on the first cycle after release with `start`=0.
- Digit 5, `code`=5'b11111, defaults → five 2-cycle tone pulses separated by 2-cycle gaps. `busy` high 24 cycles, 10 tone-high cycles, then a single `done` pulse.
- Digit 0, `code`=5'b00000 → five 6-cycle tone pulses. `busy` high 44 cycles, 30 tone-high cycles.
- Digit 1, `code`=5'b10000 → tone pattern 2 on, 2 off, then 6 on / 2 off ×3, then 6 on, 6 off. `busy` 40 cycles. Change `code` and pulse `start` mid-character → waveform unchanged, no second character.
- Reset asserted at cycle 15 of digit 1 → `tone`=0 and `busy`=0 after that edge, no `done`. Next `start` with `code`=5'b11111 plays a clean digit 5.
- Back-to-back: `start` held high continuously with `code`=5'b11111 → consecutive characters. Each `done` cycle coincides with the next character's accept, and the first tone of each new character follows the previous character's 6 off cycles directly.
